instr_prefetch_unit: RTL and testbench

//  Fetch stage directly upstream of the decoder/datapath. Issues word reads to

---
 rtl/instr_prefetch_unit.sv | 108 ++++++++++
 tb/tb_instr_prefetch_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: issues single-outstanding word fetches, queues returned
// words with their PC, and presents them to the decoder; a redirect flushes and refetches.
module instr_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [1:0]  state_dbg
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]   q_data [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic          accept, push, pop;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high;
  // a request, once valid, keeps its address until accepted or withdrawn by redirect.
  // Only issue when the queue has room for the reply, so a push can never overflow.
  assign imem_req_valid = !rst && (state_q == ST_REQ) && (count_q < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign push           = (state_q == ST_WAIT) && imem_rsp_valid;
  assign instr_valid    = (count_q != '0);
  assign pop            = instr_valid && instr_ready;
  assign instr          = q_data[rd_ptr_q];
  assign instr_pc       = q_pc[rd_ptr_q];
  assign state_dbg      = state_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      ST_REQ: begin
        if (accept) begin
          state_d    = ST_WAIT;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      ST_WAIT:    if (imem_rsp_valid) state_d = ST_REQ;
      ST_DISCARD: if (imem_rsp_valid) state_d = ST_REQ;
      default:    state_d = ST_REQ;
    endcase
    // A reply still owed to the old stream must be swallowed; one arriving this very
    // cycle settles the debt, so it must not make us drop the first new reply.
    if (redirect) begin
      fetch_pc_d = redirect_pc & ~32'h3;
      if (accept || (((state_q == ST_WAIT) || (state_q == ST_DISCARD)) && !imem_rsp_valid))
        state_d = ST_DISCARD;
      else
        state_d = ST_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (accept) req_pc_q <= fetch_pc_q;
      if (redirect) begin
        count_q  <= '0;
        rd_ptr_q <= wr_ptr_q;
      end else begin
        if (push) begin
          q_data[wr_ptr_q] <= imem_rsp_data;
          q_pc[wr_ptr_q]   <= req_pc_q;
          wr_ptr_q         <= wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: memory responder, epoch-based fetch-stream model
// checked every cycle, and directed scenarios with literal expectations.
module tb_instr_prefetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  instr_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .state_dbg(state_dbg)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  function automatic logic [31:0] at_q(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  // Model state: queue of expected {pc, word}; a reply belongs to the current stream
  // only if no reset/redirect happened since its request was accepted (epoch match).
  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_pc;
    int          epoch;
    int          due;
  } mreq_t;

  logic [63:0] exp_q[$];
  mreq_t       mem_q[$];
  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];
  int          lat = 1;
  int          cyc = 0;
  int          epoch = 0;
  bit          awaiting = 1'b0;
  bit          chk_en = 1'b0;
  logic [31:0] exp_fetch = RESET_PC;
  bit          rsp_live;
  int          rsp_epoch;
  logic [31:0] rsp_pc;
  logic        exp_valid;
  logic        accept_m;
  int          rst_cyc = 0;
  int          first_valid_cyc = -1;

  // Memory responder plus per-cycle compare against the model.
  always begin
    mreq_t m;
    @(negedge clk);
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    rsp_live       = 1'b0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(m.addr);
      rsp_live       = 1'b1;
      rsp_epoch      = m.epoch;
      rsp_pc         = m.exp_pc;
    end
    #2;
    if (chk_en) begin
      exp_valid = !rst && !awaiting && (exp_q.size() < DEPTH);
      check("req_valid", imem_req_valid, exp_valid);
      if (!rst) begin
        check("instr_valid", instr_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
          check("instr_pc", instr_pc, exp_q[0][63:32]);
          check("instr", instr, exp_q[0][31:0]);
        end
        if (!awaiting) check("req_addr", imem_req_addr, exp_fetch);
      end
      if (rst) begin
        rst_cyc = cyc;
        first_valid_cyc = -1;
      end else if (instr_valid === 1'b1 && first_valid_cyc < 0) begin
        first_valid_cyc = cyc;
      end
      if (imem_req_valid === 1'b1 && imem_req_ready) acc_log.push_back(imem_req_addr);
      if (!rst && !redirect && instr_valid === 1'b1 && instr_ready) pop_log.push_back(instr_pc);

      accept_m = exp_valid && imem_req_ready;
      if (accept_m) begin
        m.addr = imem_req_addr; m.exp_pc = exp_fetch; m.epoch = epoch; m.due = cyc + lat;
        mem_q.push_back(m);
      end
      if (rsp_live) awaiting = 1'b0;
      if (rst) begin
        exp_q.delete();
        exp_fetch = RESET_PC;
        awaiting  = 1'b0;
        epoch++;
      end else if (redirect) begin
        exp_q.delete();
        exp_fetch = redirect_pc & ~32'h3;
        epoch++;
        if (accept_m) awaiting = 1'b1;
      end else begin
        if (exp_q.size() > 0 && instr_ready) void'(exp_q.pop_front());
        if (rsp_live && rsp_epoch == epoch) exp_q.push_back({rsp_pc, mem_word(rsp_pc)});
        if (accept_m) begin
          awaiting  = 1'b1;
          exp_fetch = exp_fetch + 32'd4;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input bit flush_mem);
    @(negedge clk);
    rst = 1'b1; redirect = 1'b0; chk_en = 1'b1;
    if (flush_mem) mem_q.delete();
    acc_log.delete(); pop_log.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    // 1: streaming with 1-cycle memory and an always-ready consumer
    imem_req_ready = 1'b1; instr_ready = 1'b1; lat = 1;
    do_reset(1'b1);
    #3;
    check("t1_rst_instr_valid", instr_valid, 0);
    check("t1_rst_instr", instr, 32'h0);
    check("t1_rst_instr_pc", instr_pc, 32'h0);
    check("t1_rst_addr", imem_req_addr, RESET_PC);
    check("t1_first_req_valid", imem_req_valid, 1);
    tick(12);
    #3;
    check("t1_acc0", at_q(acc_log, 0), 32'h0);
    check("t1_acc1", at_q(acc_log, 1), 32'h4);
    check("t1_acc2", at_q(acc_log, 2), 32'h8);
    check("t1_pop0", at_q(pop_log, 0), 32'h0);
    check("t1_pop1", at_q(pop_log, 1), 32'h4);
    check("t1_pop2", at_q(pop_log, 2), 32'h8);
    check("t1_first_valid_lat", first_valid_cyc - rst_cyc, 3);

    // 2: stalled consumer fills the queue exactly, then drains in order
    instr_ready = 1'b0; lat = 1;
    do_reset(1'b1);
    tick(20);
    #3;
    check("t2_acc_count", acc_log.size(), 4);
    check("t2_acc3", at_q(acc_log, 3), 32'hC);
    check("t2_req_blocked", imem_req_valid, 0);
    check("t2_full_valid", instr_valid, 1);
    @(negedge clk);
    instr_ready = 1'b1;
    tick(14);
    #3;
    check("t2_pop0", at_q(pop_log, 0), 32'h0);
    check("t2_pop1", at_q(pop_log, 1), 32'h4);
    check("t2_pop2", at_q(pop_log, 2), 32'h8);
    check("t2_pop3", at_q(pop_log, 3), 32'hC);
    check("t2_resume", at_q(acc_log, 4), 32'h10);

    // 3: redirect to an unaligned target while a reply is outstanding
    instr_ready = 1'b0; lat = 3;
    do_reset(1'b1);
    for (int i = 0; i < 20 && acc_log.size() < 2; i++) @(negedge clk);
    check("t3_reach_wait", acc_log.size() >= 2, 1);
    redirect = 1'b1; redirect_pc = 32'h103;
    acc_log.delete(); pop_log.delete();
    #3;
    check("t3_pre_flush_valid", instr_valid, 1);
    @(negedge clk);
    redirect = 1'b0; instr_ready = 1'b1;
    #3;
    check("t3_flushed", instr_valid, 0);
    tick(15);
    #3;
    check("t3_first_addr", at_q(acc_log, 0), 32'h100);
    check("t3_first_pc", at_q(pop_log, 0), 32'h100);

    // 4: memory stall holds the request; redirect withdraws it without a discard
    imem_req_ready = 1'b0; instr_ready = 1'b1; lat = 1;
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      #3;
      check("t4_stall_valid", imem_req_valid, 1);
      check("t4_stall_addr", imem_req_addr, 32'h0);
      @(negedge clk);
    end
    redirect = 1'b1; redirect_pc = 32'h200;
    #3;
    check("t4_redir_addr_old", imem_req_addr, 32'h0);
    @(negedge clk);
    redirect = 1'b0; imem_req_ready = 1'b1;
    #3;
    check("t4_new_valid", imem_req_valid, 1);
    check("t4_new_addr", imem_req_addr, 32'h200);
    tick(8);
    #3;
    check("t4_acc0", at_q(acc_log, 0), 32'h200);
    check("t4_pop0", at_q(pop_log, 0), 32'h200);

    // 5: address wrap at the top of memory, then reset while a reply is in flight
    imem_req_ready = 1'b0; instr_ready = 1'b1; lat = 1;
    do_reset(1'b1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0; imem_req_ready = 1'b1;
    tick(8);
    #3;
    check("t5_acc0", at_q(acc_log, 0), 32'hFFFF_FFFC);
    check("t5_acc1_wrap", at_q(acc_log, 1), 32'h0);
    check("t5_acc2", at_q(acc_log, 2), 32'h4);
    check("t5_pop0", at_q(pop_log, 0), 32'hFFFF_FFFC);
    check("t5_pop1", at_q(pop_log, 1), 32'h0);
    @(negedge clk);
    lat = 4;
    n = acc_log.size();
    for (int i = 0; i < 10 && acc_log.size() <= n; i++) @(negedge clk);
    check("t5_reach_wait", acc_log.size() > n, 1);
    rst = 1'b1; imem_req_ready = 1'b0;
    acc_log.delete(); pop_log.delete();
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("t5_rst_valid", instr_valid, 0);
    check("t5_rst_addr", imem_req_addr, RESET_PC);
    check("t5_rst_req", imem_req_valid, 1);
    tick(3);
    imem_req_ready = 1'b1; lat = 1;
    tick(8);
    #3;
    check("t5_restart_acc", at_q(acc_log, 0), RESET_PC);
    check("t5_restart_pop", at_q(pop_log, 0), RESET_PC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
